// File: rtl/data_ram_responder_if.sv
// Data-memory request/response bundle between an initiator (MEM stage or
// bench) and data_ram_responder. Four-phase handshake: the initiator raises
// Enable with the request fields stable, the responder raises MOC when the
// access is finished, the initiator drops Enable, and the responder drops MOC.
// Optional macro SIGN_EXT_EN adds the Signed request field.
interface data_ram_responder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  Enable;
   logic                  ReadWrite;
   logic [1:0]            Size;
   logic [ADDR_WIDTH-1:0] Address;
   logic [31:0]           DataIn;
`ifdef SIGN_EXT_EN
   logic                  Signed;
`endif
   logic [31:0]           DataOut;
   logic                  MOC;
   logic                  Busy;
   logic                  AlignErr;

`ifdef SIGN_EXT_EN
   modport master (output Enable, ReadWrite, Size, Address, DataIn, Signed,
                   input  DataOut, MOC, Busy, AlignErr);
   modport slave  (input  Enable, ReadWrite, Size, Address, DataIn, Signed,
                   output DataOut, MOC, Busy, AlignErr);
`else
   modport master (output Enable, ReadWrite, Size, Address, DataIn,
                   input  DataOut, MOC, Busy, AlignErr);
   modport slave  (input  Enable, ReadWrite, Size, Address, DataIn,
                   output DataOut, MOC, Busy, AlignErr);
`endif
endinterface

// File: rtl/data_ram_responder.sv
// Clocked data-memory responder: 2**ADDR_WIDTH-byte big-endian array served
// through the Enable/MOC four-phase handshake with WAIT_STATES wait cycles.
// Byte, halfword and word accesses; misaligned requests complete with
// AlignErr=1 and leave the array untouched.
// Optional macro SIGN_EXT_EN: adds a Signed request bit that sign-extends
// byte and halfword reads.
// dbg_state encoding: 0 = IDLE, 1 = WAIT, 2 = DONE.
module data_ram_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                reset,
   data_ram_responder_if.slave bus,
   output logic [1:0]          dbg_state
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic                  rw_q;
   logic [1:0]            size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           din_q;
   logic [CW-1:0]         cnt;
`ifdef SIGN_EXT_EN
   logic                  signed_q;
`endif

   logic                  perform;
   logic                  misaligned;
   logic                  do_write;
   logic [ADDR_WIDTH-1:0] a1, a2, a3;
   logic [31:0]           rdata;

   assign dbg_state = state;

   // Access decode from the latched request: byte addresses, alignment, read data.
   always_comb begin
      a1         = addr_q + ADDR_WIDTH'(1);
      a2         = addr_q + ADDR_WIDTH'(2);
      a3         = addr_q + ADDR_WIDTH'(3);
      misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                   (size_q[1] && (addr_q[1:0] != 2'b00));
      perform    = (state == WAIT) && (cnt == '0);
      do_write   = perform && !rw_q && !misaligned;
      case (size_q)
         2'b00:   rdata = {24'h0, mem[addr_q]};
         2'b01:   rdata = {16'h0, mem[addr_q], mem[a1]};
         default: rdata = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
      endcase
`ifdef SIGN_EXT_EN
      if (signed_q) begin
         if (size_q == 2'b00)
            rdata[31:8] = {24{mem[addr_q][7]}};
         else if (size_q == 2'b01)
            rdata[31:16] = {16{mem[addr_q][7]}};
      end
`endif
   end

   // Array update on the perform edge; reset never clears the contents.
   always_ff @(posedge clk) begin
      if (do_write) begin
         case (size_q)
            2'b00: mem[addr_q] <= din_q[7:0];
            2'b01: begin
               mem[addr_q] <= din_q[15:8];
               mem[a1]     <= din_q[7:0];
            end
            default: begin
               mem[addr_q] <= din_q[31:24];
               mem[a1]     <= din_q[23:16];
               mem[a2]     <= din_q[15:8];
               mem[a3]     <= din_q[7:0];
            end
         endcase
      end
   end

   // Handshake FSM with registered DataOut/MOC/Busy/AlignErr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rw_q         <= 1'b1;
         size_q       <= 2'b00;
         addr_q       <= '0;
         din_q        <= 32'h0;
         cnt          <= '0;
`ifdef SIGN_EXT_EN
         signed_q     <= 1'b0;
`endif
         bus.DataOut  <= 32'h0;
         bus.MOC      <= 1'b0;
         bus.Busy     <= 1'b0;
         bus.AlignErr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Enable) begin
                  rw_q     <= bus.ReadWrite;
                  size_q   <= bus.Size;
                  addr_q   <= bus.Address;
                  din_q    <= bus.DataIn;
`ifdef SIGN_EXT_EN
                  signed_q <= bus.Signed;
`endif
                  cnt      <= CW'(WAIT_STATES);
                  bus.Busy <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (!perform) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  bus.MOC      <= 1'b1;
                  bus.AlignErr <= misaligned;
                  if (misaligned)
                     bus.DataOut <= 32'h0;
                  else if (rw_q)
                     bus.DataOut <= rdata;
                  state <= DONE;
               end
            end
            DONE: begin
               // Wait for Enable to drop so a held request is never re-triggered.
               if (!bus.Enable) begin
                  bus.MOC      <= 1'b0;
                  bus.Busy     <= 1'b0;
                  bus.AlignErr <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
